// File: rtl/vc_sec_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vc_sec_pkg
// Brief  : Shared definitions for the security-domain-aware arbitrating mux:
//          domain tag encodings, output-buffer FSM state encoding and a
//          small wrap helper used by round-robin index arithmetic.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package vc_sec_pkg;

  localparam logic DOMAIN_L = 1'b0;
  localparam logic DOMAIN_H = 1'b1;

  typedef enum logic [1:0] {
    STATE_EMPTY = 2'd0,
    STATE_FULL  = 2'd1,
    STATE_SCRUB = 2'd2
  } state_t;

  // Folds an index in [0, 2n-2] back into [0, n-1]; avoids a modulo so
  // non-power-of-two channel counts wrap explicitly.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_RoundRobinArb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vc_RoundRobinArb
// Brief  : Combinational round-robin arbiter. Scans the request vector
//          starting at ptr and wrapping at p_ninputs; the first set request
//          wins.
// Ports  : req       - request vector, one bit per channel
//          ptr       - highest-priority channel index this cycle
//          grant     - one-hot grant (all zero when no request)
//          grant_idx - encoded index of the granted channel (0 when none)
//          grant_any - at least one request present
// Rev    : 1.0  initial release
// ============================================================================
module vc_RoundRobinArb
  import vc_sec_pkg::*;
#(
  parameter  int p_ninputs   = 4,
  localparam int p_sel_nbits = $clog2(p_ninputs)
) (
  input  logic [p_ninputs-1:0]   req,
  input  logic [p_sel_nbits-1:0] ptr,
  output logic [p_ninputs-1:0]   grant,
  output logic [p_sel_nbits-1:0] grant_idx,
  output logic                   grant_any
);

  always_comb begin
    int w_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < p_ninputs; k++) begin
      w_idx = rr_wrap(int'(ptr) + k, p_ninputs);
      if (!grant_any && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = p_sel_nbits'(w_idx);
        grant_any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_sec_arb_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vc_sec_arb_mux
// Brief  : N-input round-robin arbitrating mux with a one-entry registered
//          output buffer and val/rdy handshakes. Each message carries a
//          1-bit domain tag; a one-cycle scrub bubble separates output
//          messages of different domains so the output never shows data of
//          one domain in a cycle tagged with another.
// Ports  : clk, reset           - clock, synchronous active-high reset
//          in_val/in_rdy        - per-channel handshake (in_rdy one-hot/zero)
//          in_msg               - channel i at [i*p_nbits +: p_nbits]
//          in_domain            - per-channel domain tag
//          out_val/out_rdy      - downstream handshake
//          out_msg/out_domain   - buffered message and its domain
//          out_grant            - channel that produced out_msg
// Rev    : 1.0  initial release
// ============================================================================
module vc_sec_arb_mux
  import vc_sec_pkg::*;
#(
  parameter  int p_nbits     = 32,
  parameter  int p_ninputs   = 4,
  localparam int p_sel_nbits = $clog2(p_ninputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_ninputs-1:0]           in_val,
  output logic [p_ninputs-1:0]           in_rdy,
  input  logic [p_ninputs*p_nbits-1:0]   in_msg,
  input  logic [p_ninputs-1:0]           in_domain,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_msg,
  output logic                           out_domain,
  output logic [p_sel_nbits-1:0]         out_grant
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [p_nbits-1:0]       r_msg;
  logic                     r_domain;
  logic [p_sel_nbits-1:0]   r_grant;
  logic                     r_last_domain;
  logic [p_sel_nbits-1:0]   r_ptr;

  logic [p_ninputs-1:0]     w_grant_oh;
  logic [p_sel_nbits-1:0]   w_gidx;
  logic                     w_any;
  logic                     w_can_accept;
  logic                     w_accept;
  logic                     w_out_fire;
  logic                     w_ref_domain;
  logic                     w_same_domain;
  logic [p_sel_nbits-1:0]   w_ptr_next;
  int                       w_lsb;

  vc_RoundRobinArb #(
    .p_ninputs (p_ninputs)
  ) u_arb (
    .req       (in_val),
    .ptr       (r_ptr),
    .grant     (w_grant_oh),
    .grant_idx (w_gidx),
    .grant_any (w_any)
  );

  assign w_can_accept = (r_state == STATE_EMPTY) ||
                        ((r_state == STATE_FULL) && out_rdy);
  assign w_accept     = w_any && w_can_accept;
  assign in_rdy       = w_can_accept ? w_grant_oh : '0;
  assign w_out_fire   = (r_state == STATE_FULL) && out_rdy;

  // While FULL the incoming message follows the one currently leaving, so
  // its domain is the reference; otherwise the last departed domain is.
  assign w_ref_domain  = (r_state == STATE_FULL) ? r_domain : r_last_domain;
  assign w_same_domain = (in_domain[w_gidx] == w_ref_domain);

  assign w_lsb      = int'(w_gidx) * p_nbits;
  assign w_ptr_next = (int'(w_gidx) == p_ninputs - 1) ? '0 : (w_gidx + 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      STATE_EMPTY: begin
        if (w_accept) begin
          w_state_next = w_same_domain ? STATE_FULL : STATE_SCRUB;
        end
      end
      STATE_FULL: begin
        if (w_accept) begin
          w_state_next = w_same_domain ? STATE_FULL : STATE_SCRUB;
        end else if (out_rdy) begin
          w_state_next = STATE_EMPTY;
        end
      end
      STATE_SCRUB: begin
        w_state_next = STATE_FULL;
      end
      default: begin
        w_state_next = STATE_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_msg         <= '0;
      r_domain      <= DOMAIN_L;
      r_grant       <= '0;
      r_last_domain <= DOMAIN_L;
      r_ptr         <= '0;
    end else begin
      if (w_out_fire) begin
        r_last_domain <= r_domain;
      end
      if (w_accept) begin
        r_msg    <= in_msg[w_lsb +: p_nbits];
        r_domain <= in_domain[w_gidx];
        r_grant  <= w_gidx;
        r_ptr    <= w_ptr_next;
      end
    end
  end

  // Buffer contents are masked outside FULL so a scrubbing or empty cycle
  // never exposes the held message.
  assign out_val    = (r_state == STATE_FULL);
  assign out_msg    = out_val ? r_msg    : '0;
  assign out_domain = out_val ? r_domain : r_last_domain;
  assign out_grant  = out_val ? r_grant  : '0;

endmodule

`default_nettype wire

// File: tb/tb_vc_sec_arb_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_vc_sec_arb_mux
// Brief  : Self-checking bench for vc_sec_arb_mux (4-input and 3-input
//          instances). A transaction-level reference model predicts in_rdy,
//          output visibility and the ordered stream of output messages.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vc_sec_arb_mux;

  localparam int NB = 32;
  localparam int NI = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI-1:0]     in_val = '0;
  logic [NI-1:0]     in_rdy;
  logic [NI*NB-1:0]  in_msg = '0;
  logic [NI-1:0]     in_domain = '0;
  logic              out_val;
  logic              out_rdy = 1'b0;
  logic [NB-1:0]     out_msg;
  logic              out_domain;
  logic [1:0]        out_grant;

  logic              reset3 = 1'b1;
  logic [2:0]        v3 = 3'b111;
  logic [2:0]        rdy3;
  logic [3*NB-1:0]   m3 = {32'h102, 32'h101, 32'h100};
  logic [2:0]        d3 = 3'b000;
  logic              oval3;
  logic [NB-1:0]     omsg3;
  logic              odom3;
  logic [1:0]        ogr3;

  always #5 clk = ~clk;

  vc_sec_arb_mux #(.p_nbits(NB), .p_ninputs(NI)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .in_domain(in_domain), .out_val(out_val),
    .out_rdy(out_rdy), .out_msg(out_msg), .out_domain(out_domain),
    .out_grant(out_grant)
  );

  vc_sec_arb_mux #(.p_nbits(NB), .p_ninputs(3)) dut3 (
    .clk(clk), .reset(reset3), .in_val(v3), .in_rdy(rdy3),
    .in_msg(m3), .in_domain(d3), .out_val(oval3),
    .out_rdy(1'b1), .out_msg(omsg3), .out_domain(odom3),
    .out_grant(ogr3)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [NB-1:0] msg;
    logic          dom;
    logic [1:0]    g;
  } exp_t;

  exp_t          sb[$];
  bit            m_full = 0;   // an item is held
  bit            m_vis  = 0;   // held item is past its scrub bubble
  logic [NB-1:0] m_bmsg = '0;
  logic          m_bdom = 1'b0;
  logic [1:0]    m_bgnt = '0;
  logic          m_last = 1'b0; // domain of last message delivered
  int            m_ptr  = 0;

  task automatic model_reset();
    m_full = 0; m_vis = 0; m_last = 1'b0; m_ptr = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_val = '0; out_rdy = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_out_dom", out_domain, 0);
    chk("rst_out_grant", out_grant, 0);
    chk("rst_in_rdy", in_rdy, 0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic cycle(input logic [NI-1:0] v, input logic [NI*NB-1:0] m,
                       input logic [NI-1:0] d, input logic r);
    int   g;
    bit   any, acc;
    logic [NI-1:0] exp_rdy;
    @(negedge clk);
    in_val = v; in_msg = m; in_domain = d; out_rdy = r;
    #1;
    chk("out_val", out_val, (m_full && m_vis));
    if (m_full && m_vis) begin
      chk("held_msg", out_msg, m_bmsg);
      chk("held_dom", out_domain, m_bdom);
      chk("held_grant", out_grant, m_bgnt);
    end else begin
      chk("idle_msg", out_msg, 0);
      chk("idle_grant", out_grant, 0);
      chk("idle_dom", out_domain, m_last);
    end
    any = 0; g = 0;
    for (int k = 0; k < NI; k++) begin
      int i;
      i = (m_ptr + k) % NI;
      if (!any && v[i]) begin any = 1; g = i; end
    end
    acc = any && (!m_full || (m_vis && r));
    exp_rdy = acc ? NI'(1 << g) : '0;
    chk("in_rdy", in_rdy, exp_rdy);
    @(posedge clk);
    if (m_full && m_vis && r) begin
      m_last = m_bdom; m_full = 0;
    end else if (m_full && !m_vis) begin
      m_vis = 1;
    end
    if (acc) begin
      m_full = 1;
      m_bmsg = m[g*NB +: NB];
      m_bdom = d[g];
      m_bgnt = 2'(g);
      m_vis  = (d[g] == m_last);
      sb.push_back('{msg: m[g*NB +: NB], dom: d[g], g: 2'(g)});
      m_ptr  = (g + 1) % NI;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset && out_val && out_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_msg", out_msg, e.msg);
          chk("sb_dom", out_domain, e.dom);
          chk("sb_grant", out_grant, e.g);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NI*NB-1:0] mm;
    logic [NI-1:0]    dd;
    logic             gdom;

    do_reset();

    // single message on channel 0
    cycle(4'b0001, {96'h0, 32'hA5}, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // all four valid, same domain, full throughput
    mm = {32'h13, 32'h12, 32'h11, 32'h10};
    for (int k = 0; k < 6; k++) cycle(4'b1111, mm, 4'b0000, 1'b1);
    for (int k = 0; k < 2; k++) cycle(4'b0000, '0, 4'b0000, 1'b1);

    // backpressure on 0x55
    cycle(4'b0001, {96'h0, 32'h55}, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) cycle(4'b1111, mm, 4'b0000, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // domain change L -> H
    cycle(4'b0001, {96'h0, 32'h11}, 4'b0000, 1'b1);
    cycle(4'b0010, {64'h0, 32'h22, 32'h0}, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0000, '0, 4'b0000, 1'b1);

    // reset while FULL holding 0x77 (channel 2 leaves ptr nonzero)
    cycle(4'b0100, {32'h0, 32'h77, 64'h0}, 4'b0100, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0);
    do_reset();
    cycle(4'b1111, mm, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // randomized traffic with occasional domain switches and backpressure
    gdom = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) gdom = ~gdom;
      dd = {NI{gdom}};
      if ($urandom_range(0, 4) == 0) dd = dd ^ NI'($urandom);
      mm = {$urandom, $urandom, $urandom, $urandom};
      cycle(NI'($urandom), mm, dd, ($urandom_range(0, 3) != 0));
      if (n == 700) do_reset();
    end
    for (int k = 0; k < 4; k++) cycle(4'b0000, '0, 4'b0000, 1'b1);
    chk("sb_drained", sb.size(), 0);

    // 3-input instance: grant sequence wraps 0,1,2,0,...
    @(negedge clk);
    reset3 = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("n3_val", oval3, 1);
      chk("n3_grant", ogr3, k % 3);
      chk("n3_msg", omsg3, 32'h100 + (k % 3));
      chk("n3_range", (ogr3 < 2'd3), 1);
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
